// File: rtl/frame_buf_ctrl_pkg.sv
// Shared definitions for the ping-pong frame buffer controller:
// FSM state encodings and default geometry.
package frame_buf_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH   = 19;
    localparam int DEF_FRAME_PIXELS = 307200;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_HOLD = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_EMPTY = 1'b0,
        R_SCAN  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/frame_buf_ctrl_addr_counter.sv
// Wrapping pixel address counter. clr restarts the count; clr together with
// en means "pixel 0 consumed this cycle", so the count restarts at 1.
module frame_addr_counter #(
    parameter int W   = 19,
    parameter int MAX = 307200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);

    localparam logic [W-1:0] LAST_VAL = W'(MAX - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clr)
            r_count <= en ? W'(1) : '0;
        else if (en)
            r_count <= last ? '0 : r_count + 1'b1;
    end

    assign count = r_count;
    assign last  = (r_count == LAST_VAL);

endmodule

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer scheduler: the capture side fills one bank while the
// display side scans the other; banks swap only on whole-frame boundaries.
module frame_buf_ctrl
    import frame_buf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int RD_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  wr_sof,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic                  rd_sof,
    output logic                  buf_wr_en_n,
    output logic [ADDR_WIDTH:0]   buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic                  buf_rd_en_n,
    output logic [ADDR_WIDTH:0]   buf_rd_addr,
    output logic                  frame_done,
    output logic                  frame_err
);

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic                  r_wr_bank;
    logic                  r_wr_en_n;
    logic [ADDR_WIDTH:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH:0]   r_rd_addr;
    logic                  r_frame_done;
    logic                  r_frame_err;
    logic [RD_LATENCY:0]   r_vld_pipe;
    logic [RD_LATENCY:0]   r_sof_pipe;

    logic [ADDR_WIDTH-1:0] w_wr_cnt, w_rd_cnt, w_wr_addr;
    logic                  w_wr_last, w_rd_last;
    logic                  w_wr_acc, w_wr_done, w_wr_err;
    logic                  w_rd_iss, w_swap;

    // Outside a frame only a start-of-frame pixel is taken; stray pixels drop.
    assign w_wr_acc  = wr_req & (((r_wr_state == W_IDLE) & wr_sof) | (r_wr_state == W_FILL));
    assign w_wr_done = w_wr_acc & ~wr_sof & w_wr_last;
    assign w_wr_err  = w_wr_acc & wr_sof & (r_wr_state == W_FILL);
    assign w_wr_addr = wr_sof ? '0 : w_wr_cnt;

    assign w_rd_iss  = rd_req & (r_rd_state == R_SCAN);
    assign w_swap    = (r_wr_state == W_HOLD) &
                       ((r_rd_state == R_EMPTY) | (w_rd_iss & w_rd_last));

    frame_addr_counter #(.W(ADDR_WIDTH), .MAX(FRAME_PIXELS)) u_wr_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (w_wr_acc),
        .clr   (w_wr_acc & wr_sof),
        .count (w_wr_cnt),
        .last  (w_wr_last)
    );

    frame_addr_counter #(.W(ADDR_WIDTH), .MAX(FRAME_PIXELS)) u_rd_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (w_rd_iss),
        .clr   (1'b0),
        .count (w_rd_cnt),
        .last  (w_rd_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_EMPTY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        wr_ready       = 1'b1;
        case (r_wr_state)
            W_IDLE: if (w_wr_acc) w_wr_state_nxt = W_FILL;
            W_FILL: if (w_wr_done) w_wr_state_nxt = W_HOLD;
            W_HOLD: begin
                wr_ready = 1'b0;
                if (w_swap) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_EMPTY: if (w_swap) w_rd_state_nxt = R_SCAN;
            R_SCAN:  w_rd_state_nxt = R_SCAN;
            default: w_rd_state_nxt = R_EMPTY;
        endcase
    end

    // The read bank is always the complement of the write bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank    <= 1'b0;
            r_wr_en_n    <= 1'b1;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_rd_addr    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_vld_pipe   <= '0;
            r_sof_pipe   <= '0;
        end else begin
            if (w_swap)
                r_wr_bank <= ~r_wr_bank;
            r_wr_en_n    <= ~w_wr_acc;
            if (w_wr_acc) begin
                r_wr_addr <= {r_wr_bank, w_wr_addr};
                r_wr_data <= wr_data;
            end
            if (w_rd_iss)
                r_rd_addr <= {~r_wr_bank, w_rd_cnt};
            r_frame_done <= w_wr_done;
            r_frame_err  <= w_wr_err;
            r_vld_pipe   <= {r_vld_pipe[RD_LATENCY-1:0], w_rd_iss};
            r_sof_pipe   <= {r_sof_pipe[RD_LATENCY-1:0], w_rd_iss & (w_rd_cnt == '0)};
        end
    end

    assign buf_wr_en_n = r_wr_en_n;
    assign buf_wr_addr = r_wr_addr;
    assign buf_wr_data = r_wr_data;
    assign buf_rd_en_n = ~r_vld_pipe[0];
    assign buf_rd_addr = r_rd_addr;
    assign rd_valid    = r_vld_pipe[RD_LATENCY];
    assign rd_sof      = r_sof_pipe[RD_LATENCY];
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with a 4-pixel frame and 2-cycle read latency.
module tb_frame_buf_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int FP = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_req = 1'b0;
    logic          wr_sof = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic          wr_ready, rd_valid, rd_sof;
    logic          buf_wr_en_n, buf_rd_en_n, frame_done, frame_err;
    logic [AW:0]   buf_wr_addr, buf_rd_addr;
    logic [DW-1:0] buf_wr_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    frame_buf_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(FP), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_sof(wr_sof), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_sof(rd_sof),
        .buf_wr_en_n(buf_wr_en_n), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_en_n(buf_rd_en_n), .buf_rd_addr(buf_rd_addr),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input logic req, input logic sof, input logic [DW-1:0] d);
        wr_req  = req;
        wr_sof  = sof;
        wr_data = d;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: bench did not finish in time");
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_wr_en_n", buf_wr_en_n, 1);
        chk("rst_rd_en_n", buf_rd_en_n, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_sof", rd_sof, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_wr_addr", buf_wr_addr, 0);
        chk("rst_rd_addr", buf_rd_addr, 0);
        chk("rst_wr_ready", wr_ready, 1);
        reset = 1'b1;
        tick();

        // stray pixel in idle is dropped
        drive_wr(1, 0, 8'hAA);
        tick();
        chk("idle_nosof_en_n", buf_wr_en_n, 1);
        drive_wr(0, 0, 8'h00);
        tick();
        chk("idle_nosof_en_n2", buf_wr_en_n, 1);

        // frame 1 into bank 0
        for (int i = 0; i < FP; i++) begin
            drive_wr(1, i == 0, 8'(i + 1));
            tick();
            chk("f1_wr_en_n", buf_wr_en_n, 0);
            chk("f1_wr_addr", buf_wr_addr, i);
            chk("f1_wr_data", buf_wr_data, i + 1);
            chk("f1_done", frame_done, i == FP - 1);
            chk("f1_wr_ready", wr_ready, i != FP - 1);
        end
        drive_wr(0, 0, 8'h00);
        tick();   // swap with reader empty
        chk("f1_swap_wr_ready", wr_ready, 1);
        chk("f1_done_clear", frame_done, 0);
        chk("f1_wr_en_n_idle", buf_wr_en_n, 1);

        // scan bank 0 twice, latency 2
        for (int i = 0; i < 11; i++) begin
            rd_req = (i < 8);
            tick();
            chk("scan_rd_en_n", buf_rd_en_n, (i < 8) ? 0 : 1);
            if (i < 8) chk("scan_rd_addr", buf_rd_addr, i % 4);
            chk("scan_rd_valid", rd_valid, (i >= 2 && i < 10));
            chk("scan_rd_sof", rd_sof, (i >= 2 && i < 10 && ((i - 2) % 4) == 0));
        end

        // frame 2 into bank 1 while reading; last pixel coincides with read addr 3
        rd_req = 1'b1;
        drive_wr(1, 1, 8'h05);
        tick();
        chk("f2_wr_addr0", buf_wr_addr, 4);
        chk("f2_wr_data0", buf_wr_data, 8'h05);
        chk("f2_rd_addr0", buf_rd_addr, 0);
        drive_wr(1, 0, 8'h06); tick(); chk("f2_wr_addr1", buf_wr_addr, 5);
        drive_wr(1, 0, 8'h07); tick(); chk("f2_wr_addr2", buf_wr_addr, 6);
        drive_wr(1, 0, 8'h08); tick();
        chk("f2_wr_addr3", buf_wr_addr, 7);
        chk("f2_wr_data3", buf_wr_data, 8'h08);
        chk("f2_done", frame_done, 1);
        chk("f2_wr_ready_hold", wr_ready, 0);
        chk("f2_rd_addr3", buf_rd_addr, 3);
        drive_wr(0, 0, 8'h00);
        tick();
        chk("f2_noswap_rd_addr", buf_rd_addr, 0);
        chk("f2_hold_ready", wr_ready, 0);
        tick(); chk("f2_rd_addr1", buf_rd_addr, 1);
        tick(); chk("f2_rd_addr2", buf_rd_addr, 2);
        chk("f2_pre_swap_ready", wr_ready, 0);
        drive_wr(1, 1, 8'h09);   // offered during the swap cycle
        tick();
        chk("swap_rd_addr3", buf_rd_addr, 3);
        chk("swap_wr_rejected", buf_wr_en_n, 1);
        chk("swap_wr_ready_after", wr_ready, 1);
        tick();
        chk("newbank_rd_addr", buf_rd_addr, 4);
        chk("f3_wr_en_n", buf_wr_en_n, 0);
        chk("f3_wr_addr0", buf_wr_addr, 0);
        chk("f3_wr_data0", buf_wr_data, 8'h09);
        chk("f3_rd_valid", rd_valid, 1);
        chk("f3_rd_sof0", rd_sof, 0);

        // short frame: early sof after 2 pixels
        rd_req = 1'b0;
        drive_wr(1, 0, 8'h0A); tick();
        chk("f3_wr_addr1", buf_wr_addr, 1);
        chk("f3_err_idle", frame_err, 0);
        drive_wr(1, 1, 8'h0B); tick();
        chk("err_wr_addr", buf_wr_addr, 0);
        chk("err_wr_data", buf_wr_data, 8'h0B);
        chk("err_pulse", frame_err, 1);
        chk("err_no_done", frame_done, 0);
        chk("newbank_rd_sof", rd_sof, 1);
        drive_wr(1, 0, 8'h0C); tick();
        chk("err_addr1", buf_wr_addr, 1);
        chk("err_clear", frame_err, 0);
        chk("err_done0", frame_done, 0);
        drive_wr(1, 0, 8'h0D); tick();
        chk("err_addr2", buf_wr_addr, 2);
        chk("err_done1", frame_done, 0);
        drive_wr(1, 0, 8'h0E); tick();
        chk("err_addr3", buf_wr_addr, 3);
        chk("err_done2", frame_done, 1);
        chk("err_hold_ready", wr_ready, 0);
        drive_wr(0, 0, 8'h00); tick();
        chk("hold_wait_ready", wr_ready, 0);
        chk("hold_wr_en_n", buf_wr_en_n, 1);

        // resume reading bank 1 from addr 1, swap at wrap, then reset mid-read
        rd_req = 1'b1;
        tick(); chk("g_rd_addr5", buf_rd_addr, 5);
        tick(); chk("g_rd_addr6", buf_rd_addr, 6);
        tick(); chk("g_rd_addr7", buf_rd_addr, 7);
        chk("g_swap_ready", wr_ready, 1);
        tick(); chk("g_rd_addr0", buf_rd_addr, 0);
        chk("g_rd_valid", rd_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_rd_en_n", buf_rd_en_n, 1);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_sof", rd_sof, 0);
        chk("mid_rst_rd_addr", buf_rd_addr, 0);
        chk("mid_rst_wr_en_n", buf_wr_en_n, 1);
        chk("mid_rst_wr_addr", buf_wr_addr, 0);
        chk("mid_rst_ready", wr_ready, 1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_rd_valid", rd_valid, 0);
            chk("post_rst_rd_en_n", buf_rd_en_n, 1);
        end
        rd_req = 1'b0;
        drive_wr(1, 1, 8'h55);
        tick();
        chk("post_rst_wr_en_n", buf_wr_en_n, 0);
        chk("post_rst_wr_bank0", buf_wr_addr, 0);
        chk("post_rst_wr_data", buf_wr_data, 8'h55);
        drive_wr(0, 0, 8'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
